// File: rtl/retire_stage.sv
// ----------------------------------------------------------------------------
// retire_stage
//   Two-wide in-order commit stage that sits directly behind the ROB.
//   - Each cycle it looks at the two oldest ROB entries and pops those that can
//     commit. The pop request is combinational.
//   - Each committed destination updates the retirement RAT (RRAT).
//   - The physical register that the new mapping replaces is returned to the
//     free list one cycle later.
//   - A committed mispredicted branch produces a one-cycle flush pulse with the
//     correct PC. Retirement then stalls for RECOVER_CYC cycles.
//   - A committed halt instruction parks the stage in HALT until reset.
//   - Every committed instruction is counted.
//
// Ports
//   clk, reset                 clock (rising edge); synchronous active-high reset
//   rob_valid1/2               head / head+1 entry present and complete
//   rob_pdest1/2, rob_adest1/2 physical / architectural destination
//   rob_ir1/2                  instruction word (used for halt detection)
//   rob_miss1/2, rob_target1/2 mispredicted-branch flag and its correct target
//   retire1/2                  pop request to the ROB (combinational)
//   free_valid1/2, free_idx1/2 registered free-list return
//   flush, flush_pc            pipeline flush pulse and redirect PC
//   rrat_flat                  RRAT, entry i at [i*PRF_IDX +: PRF_IDX]
//   halted                     sticky halt indication
//   retired_cnt                total committed instructions
// ----------------------------------------------------------------------------
module retire_stage #(
    parameter int PRF_IDX     = 6,
    parameter int ARF_IDX     = 5,
    parameter int ARF_SIZE    = 32,
    parameter int ZERO_REG    = 31,
    parameter int RECOVER_CYC = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rob_valid1,
    input  logic                        rob_valid2,
    input  logic [PRF_IDX-1:0]          rob_pdest1,
    input  logic [PRF_IDX-1:0]          rob_pdest2,
    input  logic [ARF_IDX-1:0]          rob_adest1,
    input  logic [ARF_IDX-1:0]          rob_adest2,
    input  logic [31:0]                 rob_ir1,
    input  logic [31:0]                 rob_ir2,
    input  logic                        rob_miss1,
    input  logic                        rob_miss2,
    input  logic [63:0]                 rob_target1,
    input  logic [63:0]                 rob_target2,
    output logic                        retire1,
    output logic                        retire2,
    output logic                        free_valid1,
    output logic                        free_valid2,
    output logic [PRF_IDX-1:0]          free_idx1,
    output logic [PRF_IDX-1:0]          free_idx2,
    output logic                        flush,
    output logic [63:0]                 flush_pc,
    output logic [ARF_SIZE*PRF_IDX-1:0] rrat_flat,
    output logic                        halted,
    output logic [63:0]                 retired_cnt
);

    typedef enum logic [1:0] {RUN, FLUSH, RECOVER, HALT} state_t;

    localparam int CNT_W = $clog2(RECOVER_CYC + 1);
    localparam logic [31:0] HALT_IR = 32'h0000_0555;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   recover_cnt;
    logic [PRF_IDX-1:0] rrat [ARF_SIZE];

    logic               halt1;
    logic               halt2;
    logic               write1;
    logic               write2;
    logic [PRF_IDX-1:0] old1;
    logic [PRF_IDX-1:0] old2;

    assign halt1 = (rob_ir1 == HALT_IR);
    assign halt2 = (rob_ir2 == HALT_IR);

    // Writes to the zero register still retire but never touch the RRAT.
    assign write1 = retire1 && (rob_adest1 != ARF_IDX'(ZERO_REG));
    assign write2 = retire2 && (rob_adest2 != ARF_IDX'(ZERO_REG));

    // When slot 2 overwrites the register slot 1 just wrote, the mapping that
    // slot 2 supersedes is slot 1's new pdest, not the stale RRAT entry.
    assign old1 = rrat[rob_adest1];
    assign old2 = (write1 && (rob_adest1 == rob_adest2)) ? rob_pdest1 : rrat[rob_adest2];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Recovery stall counter. It is cleared during FLUSH and counts while in RECOVER.
    always_ff @(posedge clk) begin
        if (reset) begin
            recover_cnt <= '0;
        end else if (state == FLUSH) begin
            recover_cnt <= '0;
        end else if (state == RECOVER) begin
            recover_cnt <= recover_cnt + CNT_W'(1);
        end
    end

    // Next-state logic. Slot 1 events take priority because slot 2 is blocked
    // whenever slot 1 is a mispredict or a halt.
    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (retire1 && rob_miss1) begin
                    state_next = FLUSH;
                end else if (retire1 && halt1) begin
                    state_next = HALT;
                end else if (retire2 && rob_miss2) begin
                    state_next = FLUSH;
                end else if (retire2 && halt2) begin
                    state_next = HALT;
                end
            end
            FLUSH: begin
                state_next = RECOVER;
            end
            RECOVER: begin
                if (recover_cnt == CNT_W'(RECOVER_CYC - 1)) begin
                    state_next = RUN;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Output decode.
    always_comb begin
        retire1 = (state == RUN) && rob_valid1;
        retire2 = retire1 && rob_valid2 && !rob_miss1 && !halt1;
        flush   = (state == FLUSH);
        halted  = (state == HALT);
    end

    // RRAT, free-list return, redirect PC and retire counter.
    // Slot 2's RRAT write comes after slot 1's, so slot 2 wins on equal adest.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARF_SIZE; i++) begin
                rrat[i] <= PRF_IDX'(i);
            end
            free_valid1 <= 1'b0;
            free_valid2 <= 1'b0;
            free_idx1   <= '0;
            free_idx2   <= '0;
            flush_pc    <= '0;
            retired_cnt <= '0;
        end else begin
            free_valid1 <= write1;
            free_valid2 <= write2;
            if (write1) begin
                free_idx1          <= old1;
                rrat[rob_adest1]   <= rob_pdest1;
            end
            if (write2) begin
                free_idx2          <= old2;
                rrat[rob_adest2]   <= rob_pdest2;
            end
            if (retire1 && rob_miss1) begin
                flush_pc <= rob_target1;
            end else if (retire2 && rob_miss2) begin
                flush_pc <= rob_target2;
            end
            retired_cnt <= retired_cnt + 64'(retire1) + 64'(retire2);
        end
    end

    for (genvar g = 0; g < ARF_SIZE; g++) begin : g_rrat_flat
        assign rrat_flat[g*PRF_IDX +: PRF_IDX] = rrat[g];
    end

endmodule

// File: tb/tb_retire_stage.sv
// ----------------------------------------------------------------------------
// tb_retire_stage
//   Directed testbench for retire_stage.
//   Inputs change 1 time unit after a rising edge. Combinational outputs are
//   examined 1 time unit after that. Registered outputs are examined 1 time
//   unit after the edge that updates them.
// ----------------------------------------------------------------------------
module tb_retire_stage;

    localparam int PRF_IDX  = 6;
    localparam int ARF_IDX  = 5;
    localparam int ARF_SIZE = 32;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        rob_valid1, rob_valid2;
    logic [PRF_IDX-1:0]          rob_pdest1, rob_pdest2;
    logic [ARF_IDX-1:0]          rob_adest1, rob_adest2;
    logic [31:0]                 rob_ir1, rob_ir2;
    logic                        rob_miss1, rob_miss2;
    logic [63:0]                 rob_target1, rob_target2;
    logic                        retire1, retire2;
    logic                        free_valid1, free_valid2;
    logic [PRF_IDX-1:0]          free_idx1, free_idx2;
    logic                        flush;
    logic [63:0]                 flush_pc;
    logic [ARF_SIZE*PRF_IDX-1:0] rrat_flat;
    logic                        halted;
    logic [63:0]                 retired_cnt;

    int n_compared   = 0;
    int n_mismatched = 0;

    retire_stage dut (
        .clk         (clk),
        .reset       (reset),
        .rob_valid1  (rob_valid1),
        .rob_valid2  (rob_valid2),
        .rob_pdest1  (rob_pdest1),
        .rob_pdest2  (rob_pdest2),
        .rob_adest1  (rob_adest1),
        .rob_adest2  (rob_adest2),
        .rob_ir1     (rob_ir1),
        .rob_ir2     (rob_ir2),
        .rob_miss1   (rob_miss1),
        .rob_miss2   (rob_miss2),
        .rob_target1 (rob_target1),
        .rob_target2 (rob_target2),
        .retire1     (retire1),
        .retire2     (retire2),
        .free_valid1 (free_valid1),
        .free_valid2 (free_valid2),
        .free_idx1   (free_idx1),
        .free_idx2   (free_idx2),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .rrat_flat   (rrat_flat),
        .halted      (halted),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rrat_of(input int i);
        return 64'(rrat_flat[i*PRF_IDX +: PRF_IDX]);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(
        input logic v1, input logic v2,
        input logic [ARF_IDX-1:0] ad1, input logic [ARF_IDX-1:0] ad2,
        input logic [PRF_IDX-1:0] pd1, input logic [PRF_IDX-1:0] pd2,
        input logic [31:0] ir1, input logic m1, input logic m2,
        input logic [63:0] t1, input logic [63:0] t2);
        rob_valid1  = v1;
        rob_valid2  = v2;
        rob_adest1  = ad1;
        rob_adest2  = ad2;
        rob_pdest1  = pd1;
        rob_pdest2  = pd2;
        rob_ir1     = ir1;
        rob_ir2     = 32'h0000_0013;
        rob_miss1   = m1;
        rob_miss2   = m2;
        rob_target1 = t1;
        rob_target2 = t2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 5'd0, 5'd0, 6'd0, 6'd0, 32'h13, 0, 0, 64'h0, 64'h0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        for (int i = 0; i < ARF_SIZE; i++) begin
            checkOutput($sformatf("reset_rrat%0d", i), rrat_of(i), 64'(i));
        end
        checkOutput("reset_retire1", 64'(retire1), 64'd0);
        checkOutput("reset_halted", 64'(halted), 64'd0);
        checkOutput("reset_flush", 64'(flush), 64'd0);
        checkOutput("reset_cnt", retired_cnt, 64'd0);
        checkOutput("reset_fv1", 64'(free_valid1), 64'd0);

        // Two independent retires
        applyStimulus(1, 1, 5'd3, 5'd4, 6'd40, 6'd41, 32'h13, 0, 0, 64'h0, 64'h0);
        checkOutput("dual_retire1", 64'(retire1), 64'd1);
        checkOutput("dual_retire2", 64'(retire2), 64'd1);
        tick();
        checkOutput("dual_fv1", 64'(free_valid1), 64'd1);
        checkOutput("dual_fi1", 64'(free_idx1), 64'd3);
        checkOutput("dual_fv2", 64'(free_valid2), 64'd1);
        checkOutput("dual_fi2", 64'(free_idx2), 64'd4);
        checkOutput("dual_rrat3", rrat_of(3), 64'd40);
        checkOutput("dual_rrat4", rrat_of(4), 64'd41);
        checkOutput("dual_cnt", retired_cnt, 64'd2);

        // Same-cycle dependence on arch reg 5
        applyStimulus(1, 1, 5'd5, 5'd5, 6'd42, 6'd43, 32'h13, 0, 0, 64'h0, 64'h0);
        tick();
        checkOutput("dep_fv1", 64'(free_valid1), 64'd1);
        checkOutput("dep_fi1", 64'(free_idx1), 64'd5);
        checkOutput("dep_fv2", 64'(free_valid2), 64'd1);
        checkOutput("dep_fi2", 64'(free_idx2), 64'd42);
        checkOutput("dep_rrat5", rrat_of(5), 64'd43);
        checkOutput("dep_cnt", retired_cnt, 64'd4);

        // Zero-register destination in slot 1 only
        applyStimulus(1, 0, 5'd31, 5'd0, 6'd50, 6'd0, 32'h13, 0, 0, 64'h0, 64'h0);
        checkOutput("zero_retire1", 64'(retire1), 64'd1);
        checkOutput("zero_retire2", 64'(retire2), 64'd0);
        tick();
        checkOutput("zero_fv1", 64'(free_valid1), 64'd0);
        checkOutput("zero_fv2", 64'(free_valid2), 64'd0);
        checkOutput("zero_rrat31", rrat_of(31), 64'd31);
        checkOutput("zero_cnt", retired_cnt, 64'd5);

        // Idle cycle: no free pulses, count unchanged
        idle();
        tick();
        checkOutput("idle_fv1", 64'(free_valid1), 64'd0);
        checkOutput("idle_cnt", retired_cnt, 64'd5);

        // Mispredict in slot 1 blocks slot 2
        applyStimulus(1, 1, 5'd6, 5'd7, 6'd44, 6'd45, 32'h13, 1, 0, 64'h1000, 64'h0);
        checkOutput("miss1_retire1", 64'(retire1), 64'd1);
        checkOutput("miss1_retire2", 64'(retire2), 64'd0);
        tick();
        checkOutput("miss1_flush", 64'(flush), 64'd1);
        checkOutput("miss1_pc", flush_pc, 64'h1000);
        checkOutput("miss1_rrat6", rrat_of(6), 64'd44);
        checkOutput("miss1_rrat7", rrat_of(7), 64'd7);
        checkOutput("miss1_cnt", retired_cnt, 64'd6);
        applyStimulus(1, 1, 5'd8, 5'd9, 6'd46, 6'd47, 32'h13, 0, 0, 64'h0, 64'h0);
        checkOutput("miss1_stall0", 64'(retire1), 64'd0);
        tick();
        checkOutput("miss1_flush_off", 64'(flush), 64'd0);
        checkOutput("miss1_stall1", 64'(retire1), 64'd0);
        tick();
        checkOutput("miss1_stall2", 64'(retire1), 64'd0);
        tick();
        checkOutput("miss1_resume1", 64'(retire1), 64'd1);
        checkOutput("miss1_resume2", 64'(retire2), 64'd1);
        checkOutput("miss1_pc_hold", flush_pc, 64'h1000);
        tick();
        checkOutput("miss1_rrat8", rrat_of(8), 64'd46);
        checkOutput("miss1_cnt2", retired_cnt, 64'd8);

        // Mispredict in slot 2 with a clean slot 1 retires both
        applyStimulus(1, 1, 5'd10, 5'd11, 6'd48, 6'd49, 32'h13, 0, 1, 64'h0, 64'h2000);
        checkOutput("miss2_retire2", 64'(retire2), 64'd1);
        tick();
        checkOutput("miss2_flush", 64'(flush), 64'd1);
        checkOutput("miss2_pc", flush_pc, 64'h2000);
        checkOutput("miss2_rrat11", rrat_of(11), 64'd49);
        checkOutput("miss2_cnt", retired_cnt, 64'd10);
        idle();
        tick();
        tick();
        tick();

        // Halt in slot 1 blocks slot 2 and parks the stage
        applyStimulus(1, 1, 5'd12, 5'd13, 6'd50, 6'd51, 32'h0000_0555, 0, 0, 64'h0, 64'h0);
        checkOutput("halt_retire1", 64'(retire1), 64'd1);
        checkOutput("halt_retire2", 64'(retire2), 64'd0);
        tick();
        checkOutput("halt_halted", 64'(halted), 64'd1);
        checkOutput("halt_rrat12", rrat_of(12), 64'd50);
        checkOutput("halt_cnt", retired_cnt, 64'd11);
        applyStimulus(1, 1, 5'd14, 5'd15, 6'd52, 6'd53, 32'h13, 0, 0, 64'h0, 64'h0);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("halt_hold_r1_%0d", k), 64'(retire1), 64'd0);
            checkOutput($sformatf("halt_hold_h_%0d", k), 64'(halted), 64'd1);
            tick();
        end
        checkOutput("halt_hold_cnt", retired_cnt, 64'd11);

        // Reset clears the halt and restores the identity mapping
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checkOutput("rst2_halted", 64'(halted), 64'd0);
        checkOutput("rst2_rrat3", rrat_of(3), 64'd3);
        checkOutput("rst2_cnt", retired_cnt, 64'd0);
        checkOutput("rst2_pc", flush_pc, 64'd0);
        checkOutput("rst2_retire1", 64'(retire1), 64'd1);
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
